// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts one full cache-line request from the cache pmem
// port into a fixed-length burst of BURST_WIDTH beats on physical memory.
//   Upstream  : address_i, read_i, write_i, line_i -> line_o, resp_o
//   Downstream: address_o, read_o, write_o, burst_o -> burst_i, resp_i
//   Clock/reset: clk, rst (synchronous, active-high)
// Optional feature macro BURST_TIMEOUT_EN: adds a per-beat watchdog and the
// err_o port; a burst with no resp_i for TIMEOUT_CYCLES is aborted with
// resp_o and err_o pulsed together.
module cacheline_adaptor #(
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned BURST_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  address_o,
    output logic                   read_o,
    output logic                   write_o,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    input  logic                   resp_i
`ifdef BURST_TIMEOUT_EN
    ,
    output logic                   err_o
`endif
);

    localparam int unsigned N     = LINE_WIDTH / BURST_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    // Elaboration-time sanity check of the geometry.
    if ((LINE_WIDTH % BURST_WIDTH) != 0 || N < 1 || TIMEOUT_CYCLES == 0 ||
        ADDR_WIDTH <= OFF_W) begin : g_param_check
        $error("cacheline_adaptor: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                          r_state, w_state_nxt;
    logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
    logic [N-1:0][BURST_WIDTH-1:0]   r_wline, w_wline_nxt;
    logic [N-1:0][BURST_WIDTH-1:0]   r_line, w_line_nxt;
    logic [ADDR_WIDTH-1:0]           r_addr, w_addr_nxt;
    logic [BURST_WIDTH-1:0]          r_burst, w_burst_nxt;
    logic                            r_read, w_read_nxt;
    logic                            r_write, w_write_nxt;
    logic                            r_resp, w_resp_nxt;
    logic                            w_last;

`ifdef BURST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]                 r_wdog, w_wdog_nxt;
    logic                            r_err, w_err_nxt;
`endif

    assign w_last = (r_cnt == CNT_W'(N - 1));

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wline_nxt = r_wline;
        w_line_nxt  = r_line;
        w_addr_nxt  = r_addr;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_resp_nxt  = 1'b0;
        w_burst_nxt = '0;
`ifdef BURST_TIMEOUT_EN
        w_wdog_nxt  = '0;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Write wins over a simultaneous read (writeback before refill).
                if (write_i) begin
                    w_state_nxt = S_WRITE;
                    w_wline_nxt = line_i;
                    w_addr_nxt  = address_i & ADDR_MASK;
                    w_cnt_nxt   = '0;
                    w_write_nxt = 1'b1;
                end else if (read_i) begin
                    w_state_nxt = S_READ;
                    w_addr_nxt  = address_i & ADDR_MASK;
                    w_cnt_nxt   = '0;
                    w_read_nxt  = 1'b1;
                end
            end
            S_WRITE: begin
                w_write_nxt = 1'b1;
                if (resp_i) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_write_nxt = 1'b0;
                        w_resp_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_READ: begin
                w_read_nxt = 1'b1;
                if (resp_i) begin
                    w_line_nxt[r_cnt] = burst_i;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        w_read_nxt  = 1'b0;
                        w_resp_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef BURST_TIMEOUT_EN
        // Watchdog counts consecutive beat-less cycles inside a burst.
        if ((r_state == S_READ || r_state == S_WRITE) && !resp_i) begin
            w_wdog_nxt = r_wdog + WD_W'(1);
            if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                w_state_nxt = S_DONE;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_resp_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_wdog_nxt  = '0;
            end
        end
`endif
        // Beat data is registered so it tracks the counter after each ack.
        if (w_state_nxt == S_WRITE) begin
            w_burst_nxt = w_wline_nxt[w_cnt_nxt];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wline <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_burst <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
`ifdef BURST_TIMEOUT_EN
            r_wdog  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wline <= w_wline_nxt;
            r_line  <= w_line_nxt;
            r_addr  <= w_addr_nxt;
            r_burst <= w_burst_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_resp  <= w_resp_nxt;
`ifdef BURST_TIMEOUT_EN
            r_wdog  <= w_wdog_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign line_o    = r_line;
    assign resp_o    = r_resp;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign burst_o   = r_burst;
`ifdef BURST_TIMEOUT_EN
    assign err_o     = r_err;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench for cacheline_adaptor (default build).
// Stimulus pushes expected burst starts, write beats and completions into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cacheline_adaptor;

    localparam int unsigned LW = 256;
    localparam int unsigned BW = 64;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] address_i = '0;
    logic          read_i = 1'b0;
    logic          write_i = 1'b0;
    logic [LW-1:0] line_i = '0;
    logic [LW-1:0] line_o;
    logic          resp_o;
    logic [AW-1:0] address_o;
    logic          read_o;
    logic          write_o;
    logic [BW-1:0] burst_o;
    logic [BW-1:0] burst_i = '0;
    logic          resp_i = 1'b0;

    cacheline_adaptor #(
        .LINE_WIDTH(LW), .BURST_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(1024)
    ) dut (
        .clk(clk), .rst(rst),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .line_i(line_i),
        .line_o(line_o), .resp_o(resp_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          is_read;
        logic [LW-1:0] line;
        int            cyc;
    } resp_t;

    resp_t         exp_resp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [1:0]    exp_kind_q[$];   // {read_o, write_o}
    logic [BW-1:0] exp_beat_q[$];
    bit            mem_pat_q[$];
    logic [BW-1:0] mem_rd_q[$];
    bit            spurious = 1'b0;
    logic [LW-1:0] last_line = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory model: acks per the queued pattern, junk data on stall cycles.
    always @(posedge clk) begin
        #1;
        if (read_o || write_o) begin
            resp_i = (mem_pat_q.size() > 0) ? mem_pat_q.pop_front() : 1'b0;
            if (resp_i && read_o && mem_rd_q.size() > 0) burst_i = mem_rd_q.pop_front();
            else                                          burst_i = {$urandom, $urandom};
        end else begin
            resp_i  = spurious;
            burst_i = {$urandom, $urandom};
        end
    end

    // Monitor / scoreboard.
    logic          prev_busy = 1'b0;
    logic          prev_resp = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    resp_t         r;
    always @(negedge clk) begin
        if (!rst) begin
            if ((read_o || write_o) && !prev_busy) begin
                if (exp_addr_q.size() == 0) fail("burst_start", "unexpected burst");
                else begin
                    cur_addr = exp_addr_q.pop_front();
                    check("burst_kind", LW'({read_o, write_o}), LW'(exp_kind_q.pop_front()));
                end
            end
            if (read_o || write_o) check("burst_addr", LW'(address_o), LW'(cur_addr));
            if (write_o) begin
                if (exp_beat_q.size() == 0) fail("write_beat", "write_o high with no beat left");
                else begin
                    check("write_beat", LW'(burst_o), LW'(exp_beat_q[0]));
                    if (resp_i) void'(exp_beat_q.pop_front());
                end
            end
            if (resp_o) begin
                if (prev_resp) fail("resp_width", "resp_o high two cycles");
                else if (exp_resp_q.size() == 0) fail("resp_unexpected", "resp_o with nothing pending");
                else begin
                    r = exp_resp_q.pop_front();
                    check("resp_cycle", LW'(cyc), LW'(r.cyc));
                    check("resp_idle_bus", LW'({read_o, write_o}), LW'(2'b00));
                    if (r.is_read) begin
                        check("read_line", line_o, r.line);
                        last_line = r.line;
                    end else begin
                        check("write_line_hold", line_o, last_line);
                        check("write_beats_left", LW'(exp_beat_q.size()), LW'(0));
                    end
                end
            end
        end
        prev_busy = read_o || write_o;
        prev_resp = resp_o;
    end

    task automatic drive_req(input bit rd, input bit wr, input logic [AW-1:0] addr,
                             input logic [LW-1:0] wl);
        read_i = rd; write_i = wr; address_i = addr; line_i = wl;
        @(posedge clk); #1;
        read_i = 1'b0; write_i = 1'b0;
        address_i = $urandom; line_i = {8{$urandom}};
    endtask

    task automatic wait_resp(input int limit);
        int n = 0;
        while (exp_resp_q.size() != 0 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_resp_q.size() != 0) begin
            fail("resp_timeout", $sformatf("no resp_o within %0d cycles", limit));
            exp_resp_q.delete(); exp_addr_q.delete(); exp_kind_q.delete();
            exp_beat_q.delete(); mem_pat_q.delete(); mem_rd_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_o"},    LW'(read_o),    LW'(0));
        check({tag, "_write_o"},   LW'(write_o),   LW'(0));
        check({tag, "_resp_o"},    LW'(resp_o),    LW'(0));
        check({tag, "_address_o"}, LW'(address_o), LW'(0));
        check({tag, "_burst_o"},   LW'(burst_o),   LW'(0));
        check({tag, "_line_o"},    line_o,         LW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        // Power-on reset.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-stall read.
        mem_pat_q = '{1, 1, 1, 1};
        mem_rd_q  = '{64'h1111111111111111, 64'h2222222222222222,
                      64'h3333333333333333, 64'h4444444444444444};
        exp_addr_q.push_back(32'h0000_1220); exp_kind_q.push_back(2'b10);
        exp_resp_q.push_back('{1'b1,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, cyc + 5});
        drive_req(1'b1, 1'b0, 32'h0000_1234, '0);
        wait_resp(40);

        // Write with stalls 1,0,0,1,1,0,1.
        mem_pat_q = '{1, 0, 0, 1, 1, 0, 1};
        exp_beat_q = '{64'hFEEDFACE_00000000, 64'h0123ABCD_00000001,
                       64'hCAFEF00D_00000002, 64'hDEADBEEF_00000003};
        exp_addr_q.push_back(32'h8000_ABC0); exp_kind_q.push_back(2'b01);
        exp_resp_q.push_back('{1'b0, '0, cyc + 8});
        drive_req(1'b0, 1'b1, 32'h8000_ABCD,
            256'hDEADBEEF00000003_CAFEF00D00000002_0123ABCD00000001_FEEDFACE00000000);
        wait_resp(40);
        @(posedge clk); #1;

        // Dirty miss: writeback then refill the cycle after resp_o.
        mem_pat_q = '{1, 1, 1, 1};
        exp_beat_q = '{64'h0C0C0C0C0C0C0C0C, 64'h0D0D0D0D0D0D0D0D,
                       64'h0E0E0E0E0E0E0E0E, 64'h0F0F0F0F0F0F0F0F};
        exp_addr_q.push_back(32'h0000_2040); exp_kind_q.push_back(2'b01);
        exp_resp_q.push_back('{1'b0, '0, cyc + 5});
        drive_req(1'b0, 1'b1, 32'h0000_2040,
            256'h0F0F0F0F0F0F0F0F_0E0E0E0E0E0E0E0E_0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C);
        wait_resp(40);
        mem_pat_q = '{1, 1, 1, 1};
        mem_rd_q  = '{64'h5A5A5A5A5A5A5A5A, 64'hA5A5A5A5A5A5A5A5,
                      64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        exp_addr_q.push_back(32'h0000_2040); exp_kind_q.push_back(2'b10);
        exp_resp_q.push_back('{1'b1,
            256'hFEDCBA9876543210_0123456789ABCDEF_A5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A, cyc + 5});
        drive_req(1'b1, 1'b0, 32'h0000_205F, '0);
        wait_resp(40);
        @(posedge clk); #1;

        // Read and write together: write wins.
        mem_pat_q = '{1, 1, 1, 1};
        exp_beat_q = '{64'h1, 64'h2, 64'h3, 64'h4};
        exp_addr_q.push_back(32'h0000_0FE0); exp_kind_q.push_back(2'b01);
        exp_resp_q.push_back('{1'b0, '0, cyc + 5});
        drive_req(1'b1, 1'b1, 32'h0000_0FFF,
            256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001);
        wait_resp(40);
        @(posedge clk); #1;

        // Read with stalls, junk on the bus during stall cycles.
        mem_pat_q = '{0, 1, 0, 0, 1, 1, 0, 1};
        mem_rd_q  = '{64'hCAFEBABE_00000000, 64'hCAFEBABE_00000001,
                      64'hCAFEBABE_00000002, 64'hCAFEBABE_00000003};
        exp_addr_q.push_back(32'hFFFF_FFE0); exp_kind_q.push_back(2'b10);
        exp_resp_q.push_back('{1'b1,
            256'hCAFEBABE00000003_CAFEBABE00000002_CAFEBABE00000001_CAFEBABE00000000, cyc + 9});
        drive_req(1'b1, 1'b0, 32'hFFFF_FFFF, '0);
        wait_resp(40);

        // Spurious acks while idle do nothing.
        spurious = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("spur_busy", LW'({read_o, write_o, resp_o}), LW'(0));
        end
        spurious = 1'b0;
        @(posedge clk); #1;
        check("spur_line_hold", line_o,
            256'hCAFEBABE00000003_CAFEBABE00000002_CAFEBABE00000001_CAFEBABE00000000);

        // Reset for two cycles mid-read after beat 1.
        mem_pat_q = '{1, 1};
        mem_rd_q  = '{64'h9999999999999999, 64'h8888888888888888};
        exp_addr_q.push_back(32'h0000_3000); exp_kind_q.push_back(2'b10);
        drive_req(1'b1, 1'b0, 32'h0000_3010, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("partial_line", line_o,
            256'hCAFEBABE00000003_CAFEBABE00000002_8888888888888888_9999999999999999);
        check("partial_read_o", LW'(read_o), LW'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        mem_pat_q.delete(); mem_rd_q.delete();
        last_line = '0;
        repeat (3) @(posedge clk);
        #1;

        // Fresh read after reset starts at beat 0.
        mem_pat_q = '{1, 1, 1, 1};
        mem_rd_q  = '{64'h7777777777777777, 64'h6666666666666666,
                      64'h5555555555555555, 64'h4444444444444444};
        exp_addr_q.push_back(32'h0000_3000); exp_kind_q.push_back(2'b10);
        exp_resp_q.push_back('{1'b1,
            256'h4444444444444444_5555555555555555_6666666666666666_7777777777777777, cyc + 5});
        drive_req(1'b1, 1'b0, 32'h0000_3010, '0);
        wait_resp(40);

        repeat (4) @(posedge clk);
        #1;
        check("end_addr_q", LW'(exp_addr_q.size()), LW'(0));
        check("end_beat_q", LW'(exp_beat_q.size()), LW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
